nios_noc_input_rx: RTL and testbench

- Receive-side counterpart of the Nios NOC output PIO: accepts 32-bit words pushed from the NOC into a show-ahead FIFO.
- The Nios drains the FIFO over a zero-wait-state Avalon-MM slave.
- Sits between the NOC router's local egress and the Nios data bus; provides an interrupt when data is pending.

---
 rtl/nios_noc_pkg.sv | 20 ++
 rtl/noc_rx_fifo.sv | 73 +++++++
 rtl/nios_noc_input_rx.sv | 93 +++++++++
 tb/tb_nios_noc_input_rx.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/nios_noc_pkg.sv
// Shared register map and bit positions for the Nios NOC input PIO.
// Imported by the receive-side top level.
package nios_noc_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_STATUS = 2'd1;
    localparam logic [1:0] ADDR_CTRL   = 2'd2;
    localparam logic [1:0] ADDR_CLEAR  = 2'd3;

    localparam int unsigned STATUS_EMPTY_BIT = 0;
    localparam int unsigned STATUS_FULL_BIT  = 1;
    localparam int unsigned STATUS_OVF_BIT   = 2;
    localparam int unsigned STATUS_COUNT_LSB = 8;
    localparam int unsigned STATUS_COUNT_W   = 8;

    localparam int unsigned CTRL_IRQ_EN_BIT = 0;
    localparam int unsigned CTRL_FLUSH_BIT  = 1;
    localparam int unsigned CLEAR_OVF_BIT   = 0;

endpackage

// File: rtl/noc_rx_fifo.sv
// Show-ahead synchronous FIFO: head is always the oldest stored word.
// Push while full and pop while empty are ignored; flush overrides both.
module noc_rx_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic              pop,
    input  logic              flush,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] head,
    output logic [PTR_W:0]    count,
    output logic              full,
    output logic              empty
);

    localparam logic [PTR_W:0]   COUNT_FULL = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0]   COUNT_ONE  = (PTR_W + 1)'(1);
    localparam logic [PTR_W-1:0] PTR_ONE    = PTR_W'(1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    count_q, count_d;
    logic              do_push, do_pop;

    assign full    = (count_q == COUNT_FULL);
    assign empty   = (count_q == '0);
    assign do_push = push & ~full & ~flush;
    assign do_pop  = pop & ~empty & ~flush;
    assign head    = mem[rd_ptr_q];
    assign count   = count_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            // Pointers are PTR_W bits wide, so wrap modulo DEPTH is implicit.
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + COUNT_ONE;
                2'b01:   count_d = count_q - COUNT_ONE;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= wdata;
    end

endmodule

// File: rtl/nios_noc_input_rx.sv
// Nios NOC input PIO: NOC words land in a show-ahead FIFO that the Nios drains
// through a zero-wait-state Avalon-MM slave; irq flags pending data.
module nios_noc_input_rx
    import nios_noc_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        address,
    input  logic              chipselect,
    input  logic              read_n,
    input  logic              write_n,
    input  logic [DATA_W-1:0] writedata,
    output logic [DATA_W-1:0] readdata,
    input  logic [DATA_W-1:0] in_port,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              irq
);

    logic              rd_strobe, wr_strobe;
    logic              pop, flush, ovf_set, ovf_clr;
    logic              full, empty;
    logic [PTR_W:0]    count;
    logic [DATA_W-1:0] head;
    logic [DATA_W-1:0] status;
    logic              irq_en_q, ovf_q;
    logic              unused_writedata;

    assign rd_strobe = chipselect & ~read_n;
    assign wr_strobe = chipselect & ~write_n;
    assign pop       = rd_strobe & (address == ADDR_DATA);
    assign flush     = wr_strobe & (address == ADDR_CTRL) & writedata[CTRL_FLUSH_BIT];
    // Flush discards the concurrent word, so it must not count as a drop.
    assign ovf_set   = in_valid & full & ~flush;
    assign ovf_clr   = wr_strobe & (address == ADDR_CLEAR) & writedata[CLEAR_OVF_BIT];

    assign unused_writedata = ^writedata[DATA_W-1:2];

    noc_rx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .PTR_W  (PTR_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (in_valid),
        .pop     (pop),
        .flush   (flush),
        .wdata   (in_port),
        .head    (head),
        .count   (count),
        .full    (full),
        .empty   (empty)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_en_q <= 1'b0;
            ovf_q    <= 1'b0;
        end else begin
            if (wr_strobe && (address == ADDR_CTRL)) irq_en_q <= writedata[CTRL_IRQ_EN_BIT];
            ovf_q <= ovf_set | (ovf_q & ~ovf_clr);
        end
    end

    always_comb begin
        status                                      = '0;
        status[STATUS_EMPTY_BIT]                    = empty;
        status[STATUS_FULL_BIT]                     = full;
        status[STATUS_OVF_BIT]                      = ovf_q;
        status[STATUS_COUNT_LSB +: STATUS_COUNT_W] = STATUS_COUNT_W'(count);
    end

    always_comb begin
        readdata = '0;
        if (rd_strobe) begin
            case (address)
                ADDR_DATA:   readdata = empty ? '0 : head;
                ADDR_STATUS: readdata = status;
                ADDR_CTRL:   readdata = DATA_W'(irq_en_q);
                default:     readdata = '0;
            endcase
        end
    end

    assign in_ready = ~full;
    assign irq      = irq_en_q & ~empty;

endmodule

// File: tb/tb_nios_noc_input_rx.sv
// Scoreboard bench: reads queue their expected readdata, a negedge monitor
// compares whenever the Avalon read strobe is active.
module tb_nios_noc_input_rx;

    typedef struct {
        logic [1:0]  addr;
        logic [31:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect, read_n, write_n;
    logic [31:0] writedata, readdata, in_port;
    logic        in_valid, in_ready, irq;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    nios_noc_input_rx #(
        .DATA_W (32),
        .DEPTH  (16)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .read_n     (read_n),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .in_port    (in_port),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .irq        (irq)
    );

    always @(negedge clk) begin
        if (reset_n && chipselect && !read_n) begin
            exp_t e;
            checks = checks + 1;
            if (sb.size() == 0) begin
                errors = errors + 1;
                $display("FAIL read_unexpected addr=%0d got=%h", address, readdata);
            end else begin
                e = sb.pop_front();
                if (readdata !== e.data || address !== e.addr) begin
                    errors = errors + 1;
                    $display("FAIL read addr=%0d got=%h exp=%h (exp addr %0d)",
                             address, readdata, e.data, e.addr);
                end
            end
        end
    end

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s got=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        in_valid = 1'b1;
        in_port  = w;
        cycle();
        in_valid = 1'b0;
    endtask

    task automatic rd(input logic [1:0] a, input logic [31:0] exp);
        exp_t e;
        e.addr = a;
        e.data = exp;
        sb.push_back(e);
        address    = a;
        chipselect = 1'b1;
        read_n     = 1'b0;
        cycle();
        chipselect = 1'b0;
        read_n     = 1'b1;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        cycle();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; address = 2'd0; chipselect = 1'b0; read_n = 1'b1; write_n = 1'b1;
        writedata = '0; in_port = '0; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 reset_n = 1'b1;
        cycle();

        // Reset state
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_irq", {31'b0, irq}, 32'd0);
        chk("idle_readdata", readdata, 32'd0);
        rd(2'd1, 32'h0000_0001);
        rd(2'd0, 32'h0);
        rd(2'd2, 32'h0);

        // Two words, irq enable, drain
        push(32'hA5A5_0001);
        push(32'hA5A5_0002);
        wr(2'd2, 32'h1);
        chk("irq_pending", {31'b0, irq}, 32'd1);
        rd(2'd1, 32'h0000_0200);
        rd(2'd0, 32'hA5A5_0001);
        chk("irq_after_first_pop", {31'b0, irq}, 32'd1);
        rd(2'd0, 32'hA5A5_0002);
        chk("irq_after_last_pop", {31'b0, irq}, 32'd0);

        // Fill to full, drop the 17th word
        for (int i = 0; i < 16; i++) push(32'h100 + i);
        chk("full_in_ready", {31'b0, in_ready}, 32'd0);
        rd(2'd1, 32'h0000_1002);
        push(32'h110);
        rd(2'd1, 32'h0000_1006);
        for (int i = 0; i < 16; i++) rd(2'd0, 32'h100 + i);
        rd(2'd1, 32'h0000_0005);
        wr(2'd3, 32'h1);
        rd(2'd1, 32'h0000_0001);

        // Full: drop concurrent with pop
        for (int i = 0; i < 16; i++) push(32'h200 + i);
        in_valid = 1'b1;
        in_port  = 32'hBEEF;
        rd(2'd0, 32'h200);
        in_valid = 1'b0;
        rd(2'd1, 32'h0000_0F04);
        rd(2'd0, 32'h201);
        wr(2'd2, 32'h3);
        rd(2'd1, 32'h0000_0005);
        rd(2'd2, 32'h1);
        wr(2'd3, 32'h1);

        // Overflow set and clear together: set wins
        for (int i = 0; i < 16; i++) push(32'h300 + i);
        in_valid = 1'b1;
        in_port  = 32'hCAFE;
        wr(2'd3, 32'h1);
        in_valid = 1'b0;
        rd(2'd1, 32'h0000_1006);
        wr(2'd2, 32'h3);
        wr(2'd3, 32'h1);
        rd(2'd1, 32'h0000_0001);

        // Push concurrent with read on empty FIFO
        in_valid = 1'b1;
        in_port  = 32'h77;
        rd(2'd0, 32'h0);
        in_valid = 1'b0;
        rd(2'd1, 32'h0000_0100);
        rd(2'd0, 32'h77);

        // Wrap-around with overlapped push/pop
        push(32'd0);
        for (int i = 1; i < 40; i++) begin
            in_valid = 1'b1;
            in_port  = i;
            rd(2'd0, i - 1);
            in_valid = 1'b0;
            rd(2'd1, 32'h0000_0100);
        end
        rd(2'd0, 32'd39);
        rd(2'd1, 32'h0000_0001);

        // Flush with 5 queued and a concurrent push; overflow held set
        for (int i = 0; i < 17; i++) push(32'h400 + i);
        wr(2'd2, 32'h3);
        for (int i = 0; i < 5; i++) push(32'h500 + i);
        rd(2'd1, 32'h0000_0504);
        in_valid = 1'b1;
        in_port  = 32'hDEAD;
        wr(2'd2, 32'h3);
        in_valid = 1'b0;
        rd(2'd1, 32'h0000_0005);
        rd(2'd2, 32'h1);
        rd(2'd0, 32'h0);
        chk("irq_after_flush", {31'b0, irq}, 32'd0);

        // Asynchronous reset mid-burst
        wr(2'd3, 32'h1);
        for (int i = 0; i < 16; i++) push(32'h600 + i);
        chk("irq_before_reset", {31'b0, irq}, 32'd1);
        in_valid = 1'b1;
        in_port  = 32'h700;
        #2 reset_n = 1'b0;
        #1;
        chk("reset_async_in_ready", {31'b0, in_ready}, 32'd1);
        chk("reset_async_irq", {31'b0, irq}, 32'd0);
        in_valid = 1'b0;
        @(posedge clk);
        #3 reset_n = 1'b1;
        cycle();
        rd(2'd1, 32'h0000_0001);
        rd(2'd2, 32'h0);
        rd(2'd0, 32'h0);

        cycle();
        checks = checks + 1;
        if (sb.size() != 0) begin
            errors = errors + 1;
            $display("FAIL scoreboard_drain left=%0d exp=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
